// File: rtl/program_loader.sv
// Boot loader: streams a framed program image into instruction memory,
// holding the core in reset until the image checksum verifies.
module program_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      next;
  logic        live;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] wcnt;
  logic [1:0]  idx;
  logic [23:0] part;
  logic [7:0]  sum;
  logic [63:0] wr_addr;

  logic        loading;
  logic        take;
  logic        restart;
  logic [15:0] n_full;
  logic        too_big;
  logic        last_word;

  assign loading   = (state == S_HDR0) || (state == S_HDR1) ||
                     (state == S_DATA) || (state == S_CHECK);
  assign rx_ready  = live && loading;
  assign take      = rx_valid && rx_ready;
  assign restart   = reload && ((state == S_RUN) || (state == S_ERR));
  assign n_full    = {rx_data, n_lo};
  assign too_big   = {1'b0, n_full} > DEPTH_W;
  assign last_word = (wcnt + 16'd1) == n_words;

  assign done      = (state == S_RUN);
  assign error     = (state == S_ERR);
  assign cpu_reset = (state != S_RUN);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HDR0;
    else        state <= next;
  end

  // Frame sequencing
  always_comb begin
    next = state;
    unique case (state)
      S_HDR0: if (take) next = S_HDR1;
      S_HDR1: begin
        if (take) begin
          if (too_big)            next = S_ERR;
          else if (n_full == '0)  next = S_CHECK;
          else                    next = S_DATA;
        end
      end
      S_DATA: begin
        if (take && idx == 2'd3 && last_word)
          next = S_CHECK;
      end
      S_CHECK: begin
        if (take) next = (rx_data == sum) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: if (reload) next = S_HDR0;
      default: next = S_HDR0;
    endcase
  end

  // Word assembly, checksum and memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live       <= 1'b0;
      n_lo       <= '0;
      n_words    <= '0;
      wcnt       <= '0;
      idx        <= '0;
      part       <= '0;
      sum        <= '0;
      wr_addr    <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      live    <= 1'b1;
      imem_we <= 1'b0;
      if (restart) begin
        n_words <= '0;
        wcnt    <= '0;
        idx     <= '0;
        part    <= '0;
        sum     <= '0;
        wr_addr <= BASE_ADDR;
      end else if (take) begin
        if (state != S_CHECK) sum <= sum ^ rx_data;
        if (state == S_HDR0) n_lo <= rx_data;
        if (state == S_HDR1) n_words <= n_full;
        if (state == S_DATA) begin
          if (idx == 2'd3) begin
            imem_we    <= 1'b1;
            imem_addr  <= wr_addr;
            imem_wdata <= {rx_data, part};
            wr_addr    <= wr_addr + 64'd4;
            wcnt       <= wcnt + 16'd1;
            idx        <= '0;
          end else begin
            part <= {rx_data, part[23:8]};
            idx  <= idx + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader placed upstream of the pipelined RISC-V core. It receives a program image as a byte stream over a valid/ready interface and writes 32-bit instruction words into instruction memory. It holds the core in reset while loading and releases it only after a checksum-verified image is in place. It owns the core's reset line and instruction-memory write port; nothing else writes instruction memory.

## Interface
- DEPTH, 64: instruction memory capacity in 32-bit words; images with more words are rejected.
- BASE_ADDR, 64'd0: byte address of the first instruction word; must be 4-byte aligned.
- clk  in  1  rising-edge clock, shared with the core.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  a byte is presented on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to restart loading from RUN or ERROR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  64  byte address of the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  active-high reset driven into the core.
- done  out  1  image loaded and verified; core running.
- error  out  1  image rejected.

## Operation
- Frame format, in order:
  - count low byte, then count high byte: N, 16-bit.
  - N words of 4 bytes each, little-endian (first byte is bits [7:0]).
  - one checksum byte.
- Checksum rule: the checksum byte must equal the XOR of every preceding byte in the frame, header included.
- A byte transfers on a rising edge with rx_valid=1 and rx_ready=1. Bytes presented without both high are ignored.
- Internal state:
  - 16-bit word counter.
  - 2-bit byte index.
  - 24-bit partial-word register.
  - 8-bit running XOR.
  - write address register.
- States and transitions:
  - HDR0: accept the count low byte -> HDR1.
  - HDR1: accept the count high byte, then check N:
    - N > DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: bytes accumulate. On the 4th byte of a word:
    - register imem_wdata = {byte3, byte2, byte1, byte0} and imem_addr = current address.
    - pulse imem_we.
    - advance the address by 4 and increment the word counter.
    - after the word counter reaches N -> CHECK.
  - CHECK: accept one byte.
    - equal to the running XOR -> RUN.
    - otherwise -> ERROR.
  - RUN: done=1, cpu_reset=0, rx_ready=0.
  - ERROR: error=1, cpu_reset=1, rx_ready=0.
  - reload=1 in RUN or ERROR -> HDR0, with these actions in the same edge:
    - clear counters and XOR.
    - reset the address to BASE_ADDR.
    - set cpu_reset=1 and clear done and error.
  - reload is ignored in every other state.
- rx_ready=1 exactly in HDR0, HDR1, DATA and CHECK.
- Words beyond those written keep their previous contents; the loader does not clear memory.

## Timing
- Reset values (asynchronous, while reset=0):
  - state = HDR0.
  - rx_ready = 0 while reset is asserted, then 1 from the first edge after deassertion.
  - imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - cpu_reset = 1, done = 0, error = 0.
- Write latency: imem_we is high during the cycle immediately after the edge that accepts a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle.
- Throughput: one byte per cycle, with no bubbles between words. Back-to-back words produce imem_we high on every 4th cycle.
- Status timing: done and cpu_reset change on the edge that accepts the checksum byte. The core therefore leaves reset one cycle after the last write strobe at the earliest, so the final word is already committed.
- N > DEPTH: ERROR is entered on the edge that accepts the count high byte. No memory write occurs.
- Reset asserted mid-load aborts immediately: imem_we drops asynchronously and the partially assembled word is discarded.
- If rx_valid drops mid-word, the partial word and byte index hold indefinitely.

## Test plan
- Load N=2, words 0x00500093 and 0x00A00113 (bytes 02 00 93 00 50 00 13 01 A0 00), checksum = XOR of those 10 bytes -> expect:
  - imem_we pulses with imem_addr 0x0 then 0x4 and matching data.
  - done=1, cpu_reset=0 one edge after the checksum byte.
- Same frame with the checksum byte inverted -> both words still written; error=1, cpu_reset stays 1, rx_ready=0.
- N=65 with DEPTH=64 (bytes 41 00) -> ERROR after the 2nd byte; imem_we never asserts.
- N=0 (bytes 00 00 00) -> no writes; done=1 after the 3rd byte.
- Deassert rx_valid for 5 cycles after byte 2 of a word -> imem_we occurs only after the 4th byte; data is unchanged versus the gap-free case.
- Assert reset during the second word, release, then send a valid N=1 frame -> loads at BASE_ADDR, done=1. Then pulse reload -> cpu_reset=1, done=0, rx_ready=1 next cycle.
